// File: rtl/dct_bfly_pipe_pkg.sv
// Shared constants and arithmetic helpers for the pipelined DCT butterfly engine.
// Coefficient sets are Q9 (512 = 1.0) in heap order, index 0 in the least-significant slot.
package dct_pkg;

   localparam int QSHIFT = 9;
   localparam int DEF_CW = 10;

   typedef logic signed [63:0] wide_t;

   localparam logic [3*DEF_CW-1:0]  COEFF_N4  = {10'd196, 10'd473, 10'd362};
   localparam logic [7*DEF_CW-1:0]  COEFF_N8  = {10'd284, 10'd425, 10'd100, 10'd502, COEFF_N4};
   localparam logic [15*DEF_CW-1:0] COEFF_N16 = {10'd325, 10'd396, 10'd241, 10'd452,
                                                 10'd149, 10'd490, 10'd50,  10'd510, COEFF_N8};
   localparam logic [31*DEF_CW-1:0] COEFF_N32 = {10'd344, 10'd379, 10'd305, 10'd411,
                                                 10'd263, 10'd439, 10'd219, 10'd463,
                                                 10'd172, 10'd482, 10'd124, 10'd497,
                                                 10'd75,  10'd506, 10'd25,  10'd511, COEFF_N16};

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Clamp a wide signed value into the range of a w-bit signed word.
   function automatic wide_t sat_w(input wide_t x, input int w);
      wide_t hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic logic sat_hit(input wide_t x, input int w);
      wide_t hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return (x > hi) || (x < lo);
   endfunction

   // Arithmetic shift rounds toward minus infinity, matching the Q9 floor.
   function automatic wide_t floor_shift(input wide_t x);
      return x >>> QSHIFT;
   endfunction

endpackage

// File: rtl/dct_bfly_pipe_if.sv
// Stream and status bundle between the transpose buffer, the butterfly engine and the quantiser.
interface dct_bfly_pipe_if #(
   parameter int N = 8,
   parameter int W = 18
);
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] d_in_flat;
   logic           out_valid;
   logic           out_ready;
   logic [N*W-1:0] d_out_flat;
   logic           sat_clr;
   logic           sat_flag;

   modport master (
      output in_valid, d_in_flat, out_ready, sat_clr,
      input  in_ready, out_valid, d_out_flat, sat_flag
   );

   modport slave (
      input  in_valid, d_in_flat, out_ready, sat_clr,
      output in_ready, out_valid, d_out_flat, sat_flag
   );
endinterface

// File: rtl/dct_bfly_pipe_stage.sv
// One registered butterfly stage: 2^STAGE groups, each with its own coefficient.
// sat_o reports a clamp on a valid vector in the cycle it is loaded.
module dct_bfly_stage
   import dct_pkg::*;
#(
   parameter int N     = 8,
   parameter int W     = 18,
   parameter int CW    = 10,
   parameter int STAGE = 0,
   parameter logic [(2**STAGE)*CW-1:0] COEFFS = '0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ready_i,
   input  logic           valid_i,
   input  logic [N*W-1:0] data_i,
   output logic           valid_o,
   output logic [N*W-1:0] data_o,
   output logic           sat_o
);

   localparam int NG = 1 << STAGE;
   localparam int G  = N >> STAGE;
   localparam int M  = G / 2;

   logic [N*W-1:0]  data_d;
   logic [N*W-1:0]  data_q;
   logic            valid_q;
   logic [NG*M-1:0] hit;

   genvar g, i;
   generate
      for (g = 0; g < NG; g++) begin : grp
         localparam logic [CW-1:0] C = COEFFS[g*CW +: CW];
         for (i = 0; i < M; i++) begin : bf
            logic signed [W-1:0]      a, b;
            logic signed [W:0]        sum, diff;
            logic signed [W+CW+1:0]   prod;
            wide_t                    scaled;

            assign a      = data_i[(g*G+i)*W +: W];
            assign b      = data_i[(g*G+i+M)*W +: W];
            assign sum    = $signed({a[W-1], a}) + $signed({b[W-1], b});
            assign diff   = $signed({a[W-1], a}) - $signed({b[W-1], b});
            // Coefficient is unsigned, so it is zero-extended before the signed multiply.
            assign prod   = $signed({{(CW+1){diff[W]}}, diff}) * $signed({{(W+1){1'b0}}, C});
            assign scaled = floor_shift(64'(prod));

            assign data_d[(g*G+i)*W +: W]   = W'(sat_w(64'(sum), W));
            assign data_d[(g*G+i+M)*W +: W] = W'(sat_w(scaled, W));
            assign hit[g*M+i] = sat_hit(64'(sum), W) | sat_hit(scaled, W);
         end
      end
   endgenerate

   // Loads on ready regardless of valid, so a bubble simply clears the valid bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (ready_i) begin
         valid_q <= valid_i;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign sat_o   = ready_i & valid_i & (|hit);

endmodule

// File: rtl/dct_bfly_pipe.sv
// N-point pipelined DCT butterfly engine: log2(N) registered stages with per-stage stall.
// Output word k is leaf k of the butterfly tree; any reordering is left to the consumer.
module dct_bfly_pipe
   import dct_pkg::*;
#(
   parameter int N  = 8,
   parameter int W  = 18,
   parameter int CW = 10,
   parameter logic [(N-1)*CW-1:0] COEFF_FLAT = COEFF_N8
) (
   input  logic              clk,
   input  logic              reset,
   dct_bfly_pipe_if.slave    bus
);

   localparam int S = clog2(N);

   logic [S:0]     stageReady;
   logic [S:0]     stageValid;
   logic [N*W-1:0] stageData [S+1];
   logic [S-1:0]   stageSat;
   logic           sat_flag_q;
   logic           sat_flag_d;

   assign stageValid[0]  = bus.in_valid;
   assign stageData[0]   = bus.d_in_flat;
   assign stageReady[S]  = bus.out_ready;
   assign bus.in_ready   = stageReady[0];
   assign bus.out_valid  = stageValid[S];
   assign bus.d_out_flat = stageData[S];
   assign bus.sat_flag   = sat_flag_q;

   genvar s;
   generate
      for (s = 0; s < S; s++) begin : stg
         // An empty stage can always take data, so bubbles collapse as the pipe drains.
         assign stageReady[s] = !stageValid[s+1] | stageReady[s+1];

         dct_bfly_stage #(
            .N      (N),
            .W      (W),
            .CW     (CW),
            .STAGE  (s),
            .COEFFS (COEFF_FLAT[((2**s)-1)*CW +: (2**s)*CW])
         ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .ready_i (stageReady[s]),
            .valid_i (stageValid[s]),
            .data_i  (stageData[s]),
            .valid_o (stageValid[s+1]),
            .data_o  (stageData[s+1]),
            .sat_o   (stageSat[s])
         );
      end
   endgenerate

   // A new saturation event overrides a simultaneous clear so no event is ever lost.
   always_comb begin
      sat_flag_d = sat_flag_q;
      if (bus.sat_clr) sat_flag_d = 1'b0;
      if (|stageSat)   sat_flag_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) sat_flag_q <= 1'b0;
      else       sat_flag_q <= sat_flag_d;
   end

endmodule

// File: tb/tb_dct_bfly_pipe.sv
// Directed bench for the 8-point, 18-bit butterfly engine with hand-computed expectations.
module tb_dct_bfly_pipe;

   localparam int N  = 8;
   localparam int W  = 18;
   localparam int VW = N * W;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   dct_bfly_pipe_if #(.N(N), .W(W)) bus ();

   dct_bfly_pipe #(.N(N), .W(W), .CW(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int asserts  = 0;
   int failures = 0;
   int cycles, accepted, nextTag, expectTag, extra;

   task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      asserts++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [VW-1:0] pack8(input int w0, input int w1, input int w2, input int w3,
                                           input int w4, input int w5, input int w6, input int w7);
      return {W'(w7), W'(w6), W'(w5), W'(w4), W'(w3), W'(w2), W'(w1), W'(w0)};
   endfunction

   task automatic applyStimulus(input logic [VW-1:0] vec, input logic clr);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.d_in_flat = vec;
      bus.sat_clr   = clr;
   endtask

   // Sends one vector into an idle pipe and checks latency and the emerging result.
   task automatic runVector(input string tag, input logic [VW-1:0] vec, input logic [VW-1:0] exp);
      int n;
      applyStimulus(vec, 1'b0);
      checkOutput({tag, " in_ready"}, VW'(bus.in_ready), VW'(1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, " latency"}, VW'(n), VW'(3));
      checkOutput({tag, " data"}, bus.d_out_flat, exp);
      @(negedge clk);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.d_in_flat = '0;
      bus.out_ready = 1'b1;
      bus.sat_clr   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset out_valid", VW'(bus.out_valid), VW'(0));
      checkOutput("reset d_out", bus.d_out_flat, '0);
      checkOutput("reset in_ready", VW'(bus.in_ready), VW'(1));
      checkOutput("reset sat_flag", VW'(bus.sat_flag), VW'(0));

      runVector("impulse", pack8(512, 0, 0, 0, 0, 0, 0, 0), pack8(512, 502, 473, 92, 362, 300, 138, 76));
      checkOutput("impulse sat_flag", VW'(bus.sat_flag), VW'(0));
      runVector("dc", pack8(100, 100, 100, 100, 100, 100, 100, 100), pack8(800, 0, 0, 0, 0, 0, 0, 0));
      checkOutput("dc sat_flag", VW'(bus.sat_flag), VW'(0));
      runVector("floor", pack8(-1, 0, 0, 0, 0, 0, 0, 0), pack8(-1, -1, -1, -1, -1, -1, -1, -1));
      runVector("sat", pack8(131071, 131071, 131071, 131071, 131071, 131071, 131071, 131071),
                pack8(131071, 0, 0, 0, 0, 0, 0, 0));
      checkOutput("sat flag set", VW'(bus.sat_flag), VW'(1));

      @(negedge clk);
      bus.sat_clr = 1'b1;
      @(negedge clk);
      bus.sat_clr = 1'b0;
      checkOutput("sat flag cleared", VW'(bus.sat_flag), VW'(0));
      applyStimulus(pack8(131071, 131071, 131071, 131071, 131071, 131071, 131071, 131071), 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.sat_clr  = 1'b0;
      checkOutput("sat set beats clear", VW'(bus.sat_flag), VW'(1));
      repeat (5) @(negedge clk);

      // Backpressure: stream tagged vectors into a blocked consumer.
      bus.out_ready = 1'b0;
      accepted = 0;
      nextTag  = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.d_in_flat = pack8(nextTag, 0, 0, 0, 0, 0, 0, 0);
         #1;
         if (bus.in_ready) begin
            accepted++;
            nextTag++;
         end
      end
      checkOutput("stall accepted", VW'(accepted), VW'(3));
      checkOutput("stall in_ready", VW'(bus.in_ready), VW'(0));
      checkOutput("stall out_valid", VW'(bus.out_valid), VW'(1));
      checkOutput("stall holds vec1", VW'(bus.d_out_flat[W-1:0]), VW'(1));
      @(negedge clk);
      checkOutput("stall stable", VW'(bus.d_out_flat[W-1:0]), VW'(1));

      expectTag = 1;
      bus.out_ready = 1'b1;
      bus.d_in_flat = pack8(nextTag, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("in_ready follows out_ready", VW'(bus.in_ready), VW'(1));
      if (bus.out_valid && bus.out_ready) begin
         checkOutput("order", VW'(bus.d_out_flat[W-1:0]), VW'(expectTag));
         expectTag++;
      end
      if (bus.in_valid && bus.in_ready) nextTag++;

      cycles = 0;
      while (expectTag <= 12 && cycles < 300) begin
         @(negedge clk);
         cycles++;
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.in_valid  = (nextTag <= 12);
         bus.d_in_flat = pack8(nextTag, 0, 0, 0, 0, 0, 0, 0);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            checkOutput("order", VW'(bus.d_out_flat[W-1:0]), VW'(expectTag));
            expectTag++;
         end
         if (bus.in_valid && bus.in_ready) nextTag++;
      end
      checkOutput("all received", VW'(expectTag), VW'(13));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.out_valid) extra++;
      end
      checkOutput("no duplicates", VW'(extra), VW'(0));

      // Reset with the pipe full must drop every in-flight vector.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.d_in_flat = pack8(21 + k, 0, 0, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("full before reset", VW'(bus.in_ready), VW'(0));
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midreset out_valid", VW'(bus.out_valid), VW'(0));
      checkOutput("midreset d_out", bus.d_out_flat, '0);
      checkOutput("midreset in_ready", VW'(bus.in_ready), VW'(1));
      checkOutput("midreset sat_flag", VW'(bus.sat_flag), VW'(0));
      reset = 1'b0;
      bus.out_ready = 1'b1;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid) extra++;
      end
      checkOutput("no stale output", VW'(extra), VW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule

// File: doc/dct_bfly_pipe.md
# dct_bfly_pipe

Parametrised N-point pipelined DCT butterfly engine, the generalised successor of the fixed 8-point, 18-bit transform core. It accepts one N-word vector per beat over a valid/ready handshake and passes it through log2(N) registered butterfly stages. Each stage has its own valid bit, and stalls propagate per stage, so bubbles collapse. Saturation is reported through a sticky status flag. It sits between the row/column transpose buffers and the quantiser.

## Interface
- `N`, 8: points per transform; must be a power of 2, from 4 to 32.
- `W`, 18: signed word width of all data, input, internal and output.
- `CW`, 10: unsigned coefficient width; coefficients are Q9, so 512 = 1.0.
- `COEFF_FLAT`, {284,425,100,502,196,473,362}: N-1 coefficients of CW bits each; index j sits at `[j*CW +: CW]`.
- `clk`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  `d_in_flat` holds a vector.
- `in_ready`  out  1  engine accepts this cycle.
- `d_in_flat`  in  N*W  word k at `[k*W +: W]`, signed.
- `out_valid`  out  1  `d_out_flat` holds a result.
- `out_ready`  in  1  consumer accepts this cycle.
- `d_out_flat`  out  N*W  word k at `[k*W +: W]`, signed.
- `sat_clr`  in  1  clears `sat_flag`.
- `sat_flag`  out  1  sticky flag: some accepted vector saturated somewhere.

## Operation
- **Stages.** There are S = log2(N) stages, s = 0..S-1.
  - Stage s splits its vector into 2^s groups of size G = N/2^s. Group g covers words g*G .. g*G+G-1, and m = G/2.
  - Within a group, a = word i and b = word i+m, for i = 0..m-1.
  - top_i = sat(a+b) goes to word i; bot_i = sat(floor((a-b)*C / 512)) goes to word i+m.
  - C is the `COEFF_FLAT` entry at index 2^s-1+g (heap order).
- **Arithmetic.**
  - a+b and a-b are formed at W+1 bits.
  - The product is formed at W+1+CW+1 bits, signed, with C zero-extended.
  - Divide-by-512 is an arithmetic shift right by 9, i.e. truncation toward minus infinity.
  - sat() clamps to [-2^(W-1), 2^(W-1)-1].
- **Output order.** Output word k is leaf k of the butterfly tree. No bit-reversal or reordering is done here; that belongs to the consumer.
- **Stage registers.** Each stage s has a data register and a valid bit v[s]. Stage S-1 drives `out_valid` and `d_out_flat`.
- **Per-stage ready.**
  - ready[S] = `out_ready`.
  - ready[s] = !v[s] | ready[s+1]; `in_ready` = ready[0].
  - A stage loads when its ready is high, taking the upstream valid bit and data; a bubble loads v=0.
  - This is a combinational chain of S terms, accepted as a timing cost.
- **Saturation flag.**
  - `sat_flag` sets on any stage load with incoming valid=1 where any clamp activates.
  - `sat_clr` clears it. If set and clear happen in the same cycle, set wins.
- **Reset.**
  - All v[s] = 0 and all data registers = 0, so `out_valid` = 0 and `d_out_flat` = 0.
  - `sat_flag` = 0 and `in_ready` = 1 on the cycle after reset is released.
  - Reset mid-operation discards all in-flight vectors, with no partial output.

## Timing
- **Latency.** S cycles from accept (`in_valid` & `in_ready` at edge t) to `out_valid` visible after edge t+S-1, when unstalled. For N=8 that is 3 cycles.
- **Throughput.** One vector per cycle with `out_ready` held high.
- **Stall capacity.** With `out_ready` = 0, exactly S vectors are accepted before `in_ready` falls. `in_ready` returns high in the same cycle `out_ready` rises, when the pipe is full.
- **Order and stability.** Order is preserved with no drop or duplicate. `d_out_flat` is stable while `out_valid` & !`out_ready`.

## Structure
- **Package `dct_pkg`:**
  - the default Q9 coefficient constant set for N = 4, 8, 16, 32 (heap order);
  - the Q-shift constant (9);
  - a `clog2` helper;
  - saturate and floor-shift functions, parametrised by W.
- **Sub-module `dct_bfly_stage`,** parametrised by N, W, CW, stage index and the coefficient slice. It contains the combinational butterflies of one stage plus the register, the valid bit and the sat output. The top level is a generate loop over S instances plus the ready chain and the flag.

## Test plan
- **Impulse.** N=8, W=18, d[0]=512, others 0 → d_out = [512,502,473,92,362,300,138,76], 3 cycles after accept.
- **DC.** All inputs 100 → word0 = 800, words 1-7 = 0, `sat_flag` = 0.
- **Floor rounding.** d[0] = -1, others 0 → all eight outputs = -1.
- **Saturation.** All inputs 131071 → word0 = 131071, others 0, `sat_flag` = 1. Then pulse `sat_clr` → 0; pulse `sat_clr` again while a saturating vector loads → `sat_flag` stays 1.
- **Backpressure.** `out_ready` = 0 with a continuous `in_valid` stream of vectors tagged word0 = 1, 2, 3, … → exactly 3 accepted, then `in_ready` = 0 and `d_out_flat` holds vector 1. Toggle `out_ready` randomly → outputs arrive in order 1, 2, 3, … with none lost or repeated.
- **Reset mid-stream.** Assert `reset` with 3 vectors in flight → next cycle `out_valid` = 0, `d_out_flat` = 0, `in_ready` = 1, and no stale vector ever emerges.
